// File: rtl/bitmap_encoder_pkg.sv
// rtl/bitmap_encoder_pkg.sv - shared widths and FSM state type for bitmap_encoder
package bitmap_encoder_pkg;

    localparam int VEC_W = 16;
    localparam int IDX_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/bitmap_encoder_prio_enc16.sv
// rtl/bitmap_encoder_prio_enc16.sv - lowest-set-bit encoder with single-bit-set flag
module prio_enc16
    import bitmap_encoder_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             one
);

    // Scan from the top down so the lowest set bit is the last to win
    always_comb begin
        idx = '0;
        for (int i = VEC_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    // Exactly one bit set: nonzero and clearing the lowest bit leaves nothing
    always_comb begin
        one = (vec != '0) && ((vec & (vec - VEC_W'(1))) == '0);
    end

endmodule

// File: rtl/bitmap_encoder.sv
// rtl/bitmap_encoder.sv - serialises a 16-bit request bitmap into set-bit indices (BITMAP_ENCODER_ZERO_BEAT_EN adds an all-zero beat)
module bitmap_encoder
    import bitmap_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [VEC_W-1:0] in_vec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             out_zero
);

    state_t           state;
    logic [VEC_W-1:0] mask;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_one;
    logic             zero_q;
    logic             in_fire;
    logic             out_fire;

    prio_enc16 u_prio_enc16 (
        .vec (mask),
        .idx (enc_idx),
        .one (enc_one)
    );

    // Handshakes and output decode; outputs are forced to zero outside SCAN
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == SCAN);
        in_fire   = in_valid && in_ready;
        out_last  = out_valid && (enc_one || zero_q);
        out_idx   = out_valid ? enc_idx : '0;
        out_zero  = out_valid && zero_q;
        out_fire  = out_valid && out_ready;
    end

    // Main FSM: load the bitmap, then retire one set bit per output handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mask  <= '0;
        end else if (state == IDLE) begin
            if (in_fire) begin
                mask <= in_vec;
`ifdef BITMAP_ENCODER_ZERO_BEAT_EN
                state <= SCAN;
`else
                if (in_vec != '0) begin
                    state <= SCAN;
                end
`endif
            end
        end else begin
            if (out_fire) begin
                mask <= mask & (mask - VEC_W'(1));
                if (out_last) begin
                    state <= IDLE;
                end
            end
        end
    end

`ifdef BITMAP_ENCODER_ZERO_BEAT_EN
    // Marks that the bitmap in flight was all-zero and needs its single report beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (in_fire) begin
            zero_q <= (in_vec == '0);
        end else if (out_fire && out_last) begin
            zero_q <= 1'b0;
        end
    end
`else
    // Zero-bitmap reporting compiled out
    always_comb begin
        zero_q = 1'b0;
    end
`endif

endmodule
